screen_scanout: RTL and testbench
=================================

Name: screen_scanout

Overview:
- Reads the CHIP-8 64x32 1bpp framebuffer over the shared byte-wide memory interface, the same one the sprite-drawing GPU writes through.
- Framebuffer layout: 8 bytes per row, MSB = leftmost pixel.
- Transposes the row-major bytes into SSD1306-style page/column bytes and streams them to the display link over a valid/ready handshake.
- Sits between the memory arbiter and the OLED serializer; one frame is sent per refresh request.

Parameters:
screen_start, 'h100, byte address of framebuffer row 0 / column byte 0 (framebuffer is 256 bytes)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
refresh  in  1  one-cycle pulse: start a frame scan (ignored while busy)
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted
mem_free  in  1  arbiter grant: a read may be issued this cycle
mem_read  out  1  one-cycle read strobe (registered)
mem_addr  out  16  read address, valid while mem_read high, 0 otherwise
mem_read_byte  in  8  read data, valid the cycle after mem_read is high
out_valid  out  1  out_byte valid
out_ready  in  1  downstream accepts out_byte
out_byte  out  8  column byte; bit k = pixel at row 8*page+k
out_first  out  1  high with the first byte of a frame (page 0, column 0)

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset mid-frame abandons the frame; no frame_done is produced. Downstream resyncs on out_first.
- Counters: page 0..3, group 0..7 (8-pixel column group), row 0..7, col 0..7. Row buffer: buf[0..7], 8 bits each.
- IDLE: refresh=1 clears the counters and moves to READ.
- READ: if mem_free, register mem_read=1 and mem_addr = screen_start + (page*8+row)*8 + group, then go to WAIT. Otherwise hold; mem_read stays 0.
- WAIT: one cycle while mem_read is high, then go to CAPTURE.
- CAPTURE: buf[row] <= mem_read_byte. If row==7, set row=0 and col=0, go to EMIT. Otherwise row++ and go to READ.
- EMIT: out_valid=1. out_byte bit k = buf[k][7-col]. out_byte is derived only from registers; there is no combinational path from inputs.
- out_first=1 only when page==0, group==0 and col==0.
- Handshake: a transfer occurs on a cycle with out_valid && out_ready. While out_ready=0, out_byte and out_first hold stable and out_valid stays high.
- On transfer: col++. At col==7, col=0 and group++ (back to READ). At group==7, group=0 and page++. At page==3 and col==7 and group==7, go to IDLE and pulse frame_done next cycle.
- Output order: page-major, then column x = 0..63 within each page. 256 bytes per frame.
- Timing, with mem_free=1 and out_ready=1:
  - refresh sampled in cycle 0; first mem_read high in cycle 2.
  - first out_valid in cycle 25.
  - each group takes 32 cycles (8 reads x 3 cycles + 8 emits); the frame takes 1024 cycles after cycle 0.
- mem_read never asserts in a cycle following mem_free=0 in READ. At most one outstanding read.
- refresh while busy: ignored, no queueing.
- mem_write is never driven; this block is read-only.

Optional Feature:
SCANOUT_SCALE2X_EN
- Defined: output targets a 128x64 panel.
  - page is 0..7; each page covers source rows 4*page..4*page+3, so only 4 reads per group (rows 0..3).
  - out_byte bit k = buf[k/2][7-col]. Each source column is emitted twice (sub-column counter), giving 16 bytes per group.
  - 1024 bytes per frame. frame_done is pulsed after page 7, group 7, col 7 sub 1.
- Undefined: behaviour exactly as above (64x32, 256 bytes).

Test Plan:
- Framebuffer all 0x00, refresh pulse, out_ready=1 -> exactly 256 transfers, all 0x00; out_first only on transfer 0; frame_done one cycle after the last transfer; total 1024 cycles.
- Only byte 'h100=0x80 set (pixel 0,0) -> transfer 0 = 0x01, all others 0x00. Only 'h1FF=0x01 set (pixel 63,31) -> transfer 255 = 0x80.
- Bytes 'h100..'h107 = 0xFF, 0x00, ... (row 0 all on) -> transfers 0..63 = 0x01; page 1..3 bytes = 0x00.
- Backpressure: out_ready low for 10 cycles at transfer 5 -> out_valid high and out_byte/out_first stable for 10 cycles, no byte lost or duplicated. mem_free toggled 1/0 every cycle -> mem_read only in granted cycles; data identical.
- Reset at cycle 300 of a frame -> next cycle all outputs 0, busy=0, no frame_done. A fresh refresh then yields a complete, correct frame. A refresh pulsed while busy produces no second frame.
- SCANOUT_SCALE2X_EN, pixel (0,0) set -> transfers 0 and 1 = 0x03, others 0x00, 1024 transfers total.

Source files
------------

// File: rtl/screen_scanout.sv
// screen_scanout: reads the CHIP-8 64x32 1bpp framebuffer over the shared byte-wide
// memory port and streams SSD1306-style page/column bytes over valid/ready.
// Optional build macro SCANOUT_SCALE2X_EN: 2x scaling for a 128x64 panel
// (8 pages of 4 source rows each, every source column emitted twice).
//
// Handshake: out_valid/out_byte/out_first are driven purely from registers. A byte
// is transferred on any cycle where out_valid && out_ready. Once out_valid rises it
// stays high and out_byte/out_first stay stable until that transfer happens.
module screen_scanout #(
    parameter logic [15:0] screen_start = 16'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        refresh,
    output logic        busy,
    output logic        frame_done,
    input  logic        mem_free,
    output logic        mem_read,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_read_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_first
);

`ifdef SCANOUT_SCALE2X_EN
    localparam logic [2:0] PAGE_LAST = 3'd7;
    localparam logic [2:0] ROW_LAST  = 3'd3;
`else
    localparam logic [2:0] PAGE_LAST = 3'd3;
    localparam logic [2:0] ROW_LAST  = 3'd7;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CAPTURE,
        S_EMIT
    } state_t;

    state_t      state;
    state_t      state_d;

    logic [2:0]  page;
    logic [2:0]  group;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [7:0]  row_buf [0:7];

    logic        col_last;
    logic        col_start;
    logic        frame_last;
    logic [7:0]  addr_off;

`ifdef SCANOUT_SCALE2X_EN
    // sub selects the first/second copy of a doubled source column
    logic        sub;
    assign col_last  = (col == 3'd7) && sub;
    assign col_start = (col == 3'd0) && !sub;
    // (page*4 + row)*8 + group
    assign addr_off  = {page, row[1:0], group};
`else
    assign col_last  = (col == 3'd7);
    assign col_start = (col == 3'd0);
    // (page*8 + row)*8 + group
    assign addr_off  = {page[1:0], row, group};
`endif

    assign frame_last = col_last && (group == 3'd7) && (page == PAGE_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d   = state;
        busy      = (state != S_IDLE);
        out_valid = (state == S_EMIT);
        out_first = 1'b0;
        case (state)
            S_IDLE: begin
                if (refresh) state_d = S_READ;
            end
            S_READ: begin
                if (mem_free) state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (row == ROW_LAST) state_d = S_EMIT;
                else                 state_d = S_READ;
            end
            S_EMIT: begin
                out_first = (page == 3'd0) && (group == 3'd0) && col_start;
                if (out_ready) begin
                    if (frame_last)    state_d = S_IDLE;
                    else if (col_last) state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transpose: bit k of the column byte comes from buffered row k (k/2 when scaled)
    always_comb begin
        out_byte = 8'h00;
        if (state == S_EMIT) begin
            for (int k = 0; k < 8; k++) begin
`ifdef SCANOUT_SCALE2X_EN
                out_byte[k] = row_buf[k / 2][3'd7 - col];
`else
                out_byte[k] = row_buf[k][3'd7 - col];
`endif
            end
        end
    end

    // Counters, row buffer, registered memory strobe and frame_done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            page       <= 3'd0;
            group      <= 3'd0;
            row        <= 3'd0;
            col        <= 3'd0;
`ifdef SCANOUT_SCALE2X_EN
            sub        <= 1'b0;
`endif
            mem_read   <= 1'b0;
            mem_addr   <= 16'h0000;
            frame_done <= 1'b0;
            for (int i = 0; i < 8; i++) row_buf[i] <= 8'h00;
        end else begin
            mem_read   <= 1'b0;
            mem_addr   <= 16'h0000;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (refresh) begin
                        page  <= 3'd0;
                        group <= 3'd0;
                        row   <= 3'd0;
                        col   <= 3'd0;
`ifdef SCANOUT_SCALE2X_EN
                        sub   <= 1'b0;
`endif
                    end
                end
                S_READ: begin
                    // one read per grant; the WAIT/CAPTURE cycles keep it single-outstanding
                    if (mem_free) begin
                        mem_read <= 1'b1;
                        mem_addr <= screen_start + {8'h00, addr_off};
                    end
                end
                S_CAPTURE: begin
                    row_buf[row] <= mem_read_byte;
                    if (row == ROW_LAST) begin
                        row <= 3'd0;
                        col <= 3'd0;
`ifdef SCANOUT_SCALE2X_EN
                        sub <= 1'b0;
`endif
                    end else begin
                        row <= row + 3'd1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (col_last) begin
                            col <= 3'd0;
`ifdef SCANOUT_SCALE2X_EN
                            sub <= 1'b0;
`endif
                            group <= group + 3'd1;
                            if (group == 3'd7) begin
                                page <= (page == PAGE_LAST) ? 3'd0 : page + 3'd1;
                            end
                            if (frame_last) frame_done <= 1'b1;
                        end else begin
`ifdef SCANOUT_SCALE2X_EN
                            sub <= ~sub;
                            if (sub) col <= col + 3'd1;
`else
                            col <= col + 3'd1;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_scanout.sv
// tb_screen_scanout: scoreboard bench for screen_scanout. A framebuffer model answers
// memory reads; expected column bytes are computed from that model and queued when a
// refresh is issued, then popped on every out_valid && out_ready transfer.
module tb_screen_scanout;

`ifdef SCANOUT_SCALE2X_EN
    localparam int FRAME_BYTES = 1024;
    localparam int PAGES       = 8;
    localparam int SUBS        = 2;
    localparam int FIRST_LAT   = 13;
    localparam int LAST_LAT    = 1792;
`else
    localparam int FRAME_BYTES = 256;
    localparam int PAGES       = 4;
    localparam int SUBS        = 1;
    localparam int FIRST_LAT   = 25;
    localparam int LAST_LAT    = 1024;
`endif
    localparam int WAIT_BUDGET = 20000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        refresh;
    logic        busy;
    logic        frame_done;
    logic        mem_free;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [7:0]  mem_read_byte = 8'hA5;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_first;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    screen_scanout #(.screen_start(16'h100)) dut (
        .clk           (clk),
        .reset         (reset),
        .refresh       (refresh),
        .busy          (busy),
        .frame_done    (frame_done),
        .mem_free      (mem_free),
        .mem_read      (mem_read),
        .mem_addr      (mem_addr),
        .mem_read_byte (mem_read_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_byte      (out_byte),
        .out_first     (out_first)
    );

    // ---------------- framebuffer model ----------------
    logic [7:0] fb [0:255];

    // read data appears the cycle after the strobe; other cycles carry junk
    always @(posedge clk) begin
        logic [15:0] off;
        off = mem_addr - 16'h100;
        if (mem_read) mem_read_byte <= fb[off[7:0]];
        else          mem_read_byte <= 8'hA5;
    end

    function automatic logic [7:0] model_byte(input int p, input int x);
        logic [7:0] r;
        logic [7:0] b;
        int         src_row;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
`ifdef SCANOUT_SCALE2X_EN
            src_row = 4 * p + k / 2;
`else
            src_row = 8 * p + k;
`endif
            b    = fb[src_row * 8 + x / 8];
            r[k] = b[7 - (x % 8)];
        end
        return r;
    endfunction

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int xfer_idx = 0;
    int last_xfer_cyc = 0;
    int first_valid_cyc = 0;
    bit seen_valid = 0;
    int frame_count = 0;
    int ref_cyc = 0;
    logic free_at_edge = 1'b1;
    bit free_toggle = 0;
    bit ready_rand = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- drivers ----------------
    always @(posedge clk) free_at_edge <= mem_free;

    always @(posedge clk) begin
        #1;
        if (free_toggle) mem_free = ~mem_free;
        if (ready_rand)  out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic fill_random();
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    endtask

    task automatic start_frame();
        for (int p = 0; p < PAGES; p++)
            for (int x = 0; x < 64; x++)
                for (int s = 0; s < SUBS; s++)
                    exp_q.push_back(model_byte(p, x));
        xfer_idx   = 0;
        seen_valid = 0;
        @(posedge clk); #1;
        refresh = 1'b1;
        ref_cyc = cyc;
        @(posedge clk); #1;
        refresh = 1'b0;
    endtask

    task automatic wait_frame_done();
        int start;
        int n;
        start = frame_count;
        n = 0;
        while (frame_count == start && n < WAIT_BUDGET) begin
            @(posedge clk);
            n++;
        end
        check("frame_done_timeout", frame_count != start, 1);
        if (frame_count == start) exp_q.delete();
    endtask

    task automatic finish_frame_checks(input bit ideal);
        if (ideal) begin
            check("first_valid_latency", first_valid_cyc - ref_cyc, FIRST_LAT);
            check("last_xfer_latency", last_xfer_cyc - ref_cyc, LAST_LAT);
        end
        check("frame_xfers", xfer_idx, FRAME_BYTES);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("busy_after_frame", busy, 0);
    endtask

    task automatic run_frame(input bit ideal);
        start_frame();
        wait_frame_done();
        finish_frame_checks(ideal);
    endtask

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (out_valid && !seen_valid) begin
            seen_valid      = 1;
            first_valid_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            check("xfer_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                check("out_byte", out_byte, exp_b);
            end
            check("out_first", out_first, xfer_idx == 0);
            xfer_idx++;
            last_xfer_cyc = cyc;
        end
        if (frame_done) begin
            frame_count++;
            check("done_latency", cyc - last_xfer_cyc, 1);
            check("done_count", xfer_idx, FRAME_BYTES);
        end
        if (mem_read) begin
            check("read_grant", free_at_edge, 1);
            check("read_addr_range", mem_addr[15:8] == 8'h01, 1);
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int guard;
        int saved;
        reset     = 1'b1;
        refresh   = 1'b0;
        mem_free  = 1'b1;
        out_ready = 1'b1;
        fill_zero();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_out_first", out_first, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // all-zero frame, ideal timing
        run_frame(1);

        // single pixel (0,0)
        fill_zero(); fb[0] = 8'h80;
        run_frame(1);

        // single pixel (63,31)
        fill_zero(); fb[255] = 8'h01;
        run_frame(1);

        // row 0 fully lit
        fill_zero();
        for (int i = 0; i < 8; i++) fb[i] = 8'hFF;
        run_frame(1);

        // backpressure: hold out_ready low for 10 cycles at transfer 5
        fill_random();
        start_frame();
        guard = 0;
        while (xfer_idx != 5 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check("stall_reached", xfer_idx, 5);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            if (exp_q.size() != 0) check("stall_byte", out_byte, exp_q[0]);
            check("stall_first", out_first, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_frame_done();
        finish_frame_checks(0);

        // arbiter grant toggling every cycle
        fill_random();
        free_toggle = 1;
        run_frame(0);
        free_toggle = 0;
        @(posedge clk); #1 mem_free = 1'b1;

        // random downstream readiness plus toggling grant
        fill_random();
        free_toggle = 1;
        ready_rand  = 1;
        run_frame(0);
        free_toggle = 0;
        ready_rand  = 0;
        @(posedge clk); #1;
        mem_free  = 1'b1;
        out_ready = 1'b1;

        // reset mid-frame abandons it
        fill_random();
        saved = frame_count;
        start_frame();
        repeat (300) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_mem_read", mem_read, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_out_byte", out_byte, 0);
        check("midrst_out_first", out_first, 0);
        exp_q.delete();
        repeat (800) @(posedge clk);
        check("midrst_no_done", frame_count, saved);

        // fresh frame after reset, with a refresh pulsed while busy
        fill_random();
        saved = frame_count;
        start_frame();
        repeat (100) @(posedge clk);
        #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
        wait_frame_done();
        finish_frame_checks(1);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("busy_refresh_ignored", busy, 0);
        check("single_frame_count", frame_count, saved + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
